// File: rtl/mem_requester.sv
// mem_requester: initiator side of one bank's memory handshake.
// A command is taken on a valid/ready interface, presented to the bank with
// stable address/data until the bank acks, and read data is returned through
// a one-entry response buffer. Completed transactions are counted, and a
// sticky flag records any request that waited too long for its ack.
module mem_requester #(
    parameter int TX_DATA_WIDTH   = 8,
    parameter int BANK_ADDR_WIDTH = 4,
    parameter int COL_ADDR_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    // command interface from the grid scan/update logic
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [BANK_ADDR_WIDTH-1:0] cmd_row,
    input  logic [COL_ADDR_WIDTH-1:0]  cmd_col,
    input  logic                       cmd_pad,
    input  logic [TX_DATA_WIDTH-1:0]   cmd_data,
    // read response interface
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [TX_DATA_WIDTH-1:0]   rsp_data,
    output logic                       wr_done,
    // bank handshake
    output logic                       mem_write_en,
    output logic                       mem_read_en,
    output logic                       mem_pad_en,
    output logic [BANK_ADDR_WIDTH-1:0] mem_row_addr,
    output logic [COL_ADDR_WIDTH-1:0]  mem_col_addr,
    output logic [TX_DATA_WIDTH-1:0]   mem_data_out,
    input  logic                       mem_ack,
    input  logic [TX_DATA_WIDTH-1:0]   mem_data_in,
    // status
    output logic [COUNT_WIDTH-1:0]     txn_count,
    output logic                       err_timeout
);

    // Wide enough to hold TIMEOUT_CYCLES itself so the counter can saturate.
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                     state_r;
    logic                       cmd_write_r;
    logic                       cmd_pad_r;
    logic [BANK_ADDR_WIDTH-1:0] cmd_row_r;
    logic [COL_ADDR_WIDTH-1:0]  cmd_col_r;
    logic [TX_DATA_WIDTH-1:0]   cmd_data_r;
    logic                       rsp_valid_r;
    logic [TX_DATA_WIDTH-1:0]   rsp_data_r;
    logic [COUNT_WIDTH-1:0]     txn_count_r;
    logic [TMR_W-1:0]           timer_r;
    logic                       err_timeout_r;

    // Handshake FSM: command capture, bank request, response hold, counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cmd_write_r   <= 1'b0;
            cmd_pad_r     <= 1'b0;
            cmd_row_r     <= '0;
            cmd_col_r     <= '0;
            cmd_data_r    <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= '0;
            txn_count_r   <= '0;
            timer_r       <= '0;
            err_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Command registers double as the bank-facing address and
                    // data lines, so they only change here and stay put in REQ.
                    if (cmd_valid) begin
                        cmd_write_r <= cmd_write;
                        cmd_pad_r   <= cmd_pad;
                        cmd_row_r   <= cmd_row;
                        cmd_col_r   <= cmd_col;
                        cmd_data_r  <= cmd_data;
                        timer_r     <= '0;
                        state_r     <= ST_REQ;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        txn_count_r <= txn_count_r + COUNT_WIDTH'(1);
                        if (cmd_write_r) begin
                            state_r     <= ST_IDLE;
                        end else begin
                            rsp_data_r  <= mem_data_in;
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RSP;
                        end
                    end else begin
                        // Keep waiting; a stall is only flagged, never aborted.
                        if (timer_r != TMR_W'(TIMEOUT_CYCLES)) begin
                            timer_r <= timer_r + TMR_W'(1);
                        end
                        if (timer_r == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                            err_timeout_r <= 1'b1;
                        end
                        state_r <= ST_REQ;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RSP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Enables decode the state register only, so the cycle after an ack they
    // are already low and the bank cannot see the same request twice.
    assign cmd_ready    = (state_r == ST_IDLE);
    assign mem_read_en  = (state_r == ST_REQ) && !cmd_write_r;
    assign mem_write_en = (state_r == ST_REQ) &&  cmd_write_r;

    // Write completion is reported in the ack cycle itself.
    assign wr_done      = (state_r == ST_REQ) && cmd_write_r && mem_ack;

    assign mem_pad_en   = cmd_pad_r;
    assign mem_row_addr = cmd_row_r;
    assign mem_col_addr = cmd_col_r;
    assign mem_data_out = cmd_data_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign txn_count    = txn_count_r;
    assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_mem_requester.sv
// Testbench for mem_requester: a behavioural bank (open-row hit/miss timing)
// answers requests, a vector table drives the main command mix, and
// hand-written sequences cover backpressure, stability, timeout, reset and
// counter wrap. Expected read data goes through a scoreboard queue.
module tb_mem_requester;

    localparam int TXW         = 8;
    localparam int BAW         = 4;
    localparam int CAW         = 3;
    localparam int CW          = 2;
    localparam int TO          = 64;
    localparam int NROW        = 16;
    localparam int NCOL        = 8;
    localparam int ACK_BUDGET  = 20;

    logic           clock;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_write;
    logic [BAW-1:0] cmd_row;
    logic [CAW-1:0] cmd_col;
    logic           cmd_pad;
    logic [TXW-1:0] cmd_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [TXW-1:0] rsp_data;
    logic           wr_done;
    logic           mem_write_en;
    logic           mem_read_en;
    logic           mem_pad_en;
    logic [BAW-1:0] mem_row_addr;
    logic [CAW-1:0] mem_col_addr;
    logic [TXW-1:0] mem_data_out;
    logic           mem_ack;
    logic [TXW-1:0] mem_data_in;
    logic [CW-1:0]  txn_count;
    logic           err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    mem_requester #(
        .TX_DATA_WIDTH  (TXW),
        .BANK_ADDR_WIDTH(BAW),
        .COL_ADDR_WIDTH (CAW),
        .TIMEOUT_CYCLES (TO),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .cmd_pad     (cmd_pad),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .wr_done     (wr_done),
        .mem_write_en(mem_write_en),
        .mem_read_en (mem_read_en),
        .mem_pad_en  (mem_pad_en),
        .mem_row_addr(mem_row_addr),
        .mem_col_addr(mem_col_addr),
        .mem_data_out(mem_data_out),
        .mem_ack     (mem_ack),
        .mem_data_in (mem_data_in),
        .txn_count   (txn_count),
        .err_timeout (err_timeout)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural bank ----------------
    // Read hit acks in the 1st enabled cycle, write hit in the 2nd, any miss
    // in the 3rd. A miss opens the row at its ack.
    logic           bank_clear;
    logic           stub_never_ack;
    logic           ack_inject;
    logic           bank_open_valid;
    logic [BAW-1:0] bank_open_row;
    int             bank_wait;
    int             bank_need;
    int             wb_count;
    logic           bank_ack;
    logic [TXW-1:0] bank_mem [0:NROW-1][0:NCOL-1];

    // Bank ack decision from the open row and cycles spent in the request.
    always_comb begin
        bank_need = 2;
        if (bank_open_valid && (bank_open_row == mem_row_addr)) begin
            bank_need = mem_write_en ? 1 : 0;
        end else begin
            bank_need = 2;
        end
        bank_ack = (mem_read_en || mem_write_en) && !stub_never_ack && (bank_wait == bank_need);
    end

    assign mem_ack     = bank_ack | ack_inject;
    assign mem_data_in = bank_mem[mem_row_addr][mem_col_addr];

    // Bank state: wait counter, open row, storage and write-back count.
    always @(posedge clock) begin
        if (bank_clear) begin
            for (int r = 0; r < NROW; r++) begin
                for (int c = 0; c < NCOL; c++) begin
                    bank_mem[r][c] <= '0;
                end
            end
            wb_count <= 0;
        end
        if (reset) begin
            bank_wait       <= 0;
            bank_open_valid <= 1'b0;
            bank_open_row   <= '0;
        end else begin
            if ((mem_read_en || mem_write_en) && !mem_ack) bank_wait <= bank_wait + 1;
            else bank_wait <= 0;
            if (bank_ack) begin
                bank_open_valid <= 1'b1;
                bank_open_row   <= mem_row_addr;
                if (mem_write_en) begin
                    bank_mem[mem_row_addr][mem_col_addr + CAW'(mem_pad_en)] <= mem_data_out;
                    wb_count <= wb_count + 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic           w;
        logic [BAW-1:0] row;
        logic [CAW-1:0] col;
        logic           pad;
        logic [TXW-1:0] data;
        int             ack_cyc;
        logic [TXW-1:0] rd;
    } vec_t;

    vec_t           tbl [8];
    logic [TXW-1:0] sb_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [BAW-1:0] r, input logic [CAW-1:0] c,
                         input logic p, input logic [TXW-1:0] d);
        chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_write = w;
        cmd_row   = r;
        cmd_col   = c;
        cmd_pad   = p;
        cmd_data  = d;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Returns the REQ cycle (1-based) holding the ack, 0 if none in budget.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        for (int c = 1; c <= ACK_BUDGET && cyc == 0; c++) begin
            if (mem_ack) cyc = c;
            else step();
        end
    endtask

    task automatic finish_txn(input logic w);
        logic [TXW-1:0] exp_d;
        if (w) begin
            chk("wr_done_on_ack", {31'd0, wr_done}, 32'd1);
            step();
            chk("wr_en_drop", {31'd0, mem_write_en}, 32'd0);
            chk("wr_done_pulse_end", {31'd0, wr_done}, 32'd0);
        end else begin
            step();
            chk("rd_en_drop", {31'd0, mem_read_en}, 32'd0);
            exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_d});
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk("rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        if (!v.w) sb_q.push_back(v.rd);
        issue(v.w, v.row, v.col, v.pad, v.data);
        chk("en_cycle1", {31'd0, (v.w ? mem_write_en : mem_read_en)}, 32'd1);
        wait_ack(cyc);
        chk("ack_cycle", cyc, v.ack_cyc);
        finish_txn(v.w);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int             cyc;
        int             wb0;
        logic [TXW-1:0] hold_d;
        vec_t           v;

        tbl[0] = '{1'b1, 4'd3, 3'd1, 1'b0, 8'hA5, 3, 8'h00};
        tbl[1] = '{1'b0, 4'd3, 3'd1, 1'b0, 8'h00, 1, 8'hA5};
        tbl[2] = '{1'b1, 4'd3, 3'd2, 1'b1, 8'h3C, 2, 8'h00};
        tbl[3] = '{1'b0, 4'd3, 3'd3, 1'b0, 8'h00, 1, 8'h3C};
        tbl[4] = '{1'b0, 4'd5, 3'd0, 1'b0, 8'h00, 3, 8'h00};
        tbl[5] = '{1'b1, 4'd5, 3'd0, 1'b0, 8'h5A, 2, 8'h00};
        tbl[6] = '{1'b0, 4'd3, 3'd1, 1'b0, 8'h00, 3, 8'hA5};
        tbl[7] = '{1'b0, 4'd5, 3'd0, 1'b0, 8'h00, 3, 8'h5A};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_row = '0; cmd_col = '0;
        cmd_pad = 1'b0; cmd_data = '0; rsp_ready = 1'b0; stub_never_ack = 1'b0;
        ack_inject = 1'b0; bank_clear = 1'b1;
        step();
        bank_clear = 1'b0;
        do_reset();

        // reset values
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
        chk("rst_enables", {30'd0, mem_write_en, mem_read_en}, 32'd0);
        chk("rst_addr", {24'd0, mem_pad_en, mem_row_addr, mem_col_addr}, 32'd0);
        chk("rst_data", {24'd0, mem_data_out}, 32'd0);
        chk("rst_txn_count", {30'd0, txn_count}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);

        // table-driven command mix: write miss, read hit, pad, misses, wrap
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
            chk("txn_count_tbl", {30'd0, txn_count}, (i + 1) % 4);
        end

        // timeout: stalled read acked late at REQ cycle 70
        do_reset();
        v = '{1'b1, 4'd7, 3'd6, 1'b0, 8'h96, 3, 8'h00};
        run_vec(v);
        stub_never_ack = 1'b1;
        sb_q.push_back(8'h96);
        issue(1'b0, 4'd7, 3'd6, 1'b0, 8'h00);
        for (int c = 1; c < 70; c++) begin
            if (c == 64) chk("err_before_64", {31'd0, err_timeout}, 32'd0);
            if (c == 65) begin
                chk("err_after_64", {31'd0, err_timeout}, 32'd1);
                chk("still_req_rd_en", {31'd0, mem_read_en}, 32'd1);
                chk("still_req_busy", {31'd0, cmd_ready}, 32'd0);
            end
            step();
        end
        chk("late_ack_rd_en", {31'd0, mem_read_en}, 32'd1);
        ack_inject = 1'b1;
        #1;
        finish_txn(1'b0);
        ack_inject = 1'b0;
        stub_never_ack = 1'b0;
        chk("timeout_txn_count", {30'd0, txn_count}, 32'd2);
        chk("err_sticky", {31'd0, err_timeout}, 32'd1);

        // reset in the 2nd REQ cycle of a write
        wb0 = wb_count;
        issue(1'b1, 4'd10, 3'd2, 1'b0, 8'h77);
        step();
        chk("midrst_in_req", {31'd0, mem_write_en}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_enables", {30'd0, mem_write_en, mem_read_en}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_txn_count", {30'd0, txn_count}, 32'd0);
        chk("midrst_wr_done", {31'd0, wr_done}, 32'd0);
        chk("midrst_err", {31'd0, err_timeout}, 32'd0);
        chk("midrst_bank_row", {24'd0, bank_mem[10][2]}, 32'd0);
        chk("midrst_no_wb", wb_count - wb0, 32'd0);

        // backpressure: response held 5 cycles, next command waits
        sb_q.push_back(8'h96);
        issue(1'b0, 4'd7, 3'd6, 1'b0, 8'h00);
        wait_ack(cyc);
        chk("bp_ack_cycle", cyc, 32'd3);
        step();
        hold_d = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        cmd_write = 1'b1; cmd_row = 4'd7; cmd_col = 3'd0; cmd_pad = 1'b0; cmd_data = 8'h11;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {24'd0, rsp_data}, {24'd0, hold_d});
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_released", {31'd0, rsp_valid}, 32'd0);
        chk("bp_ready_again", {31'd0, cmd_ready}, 32'd1);
        chk("bp_not_yet_taken", {31'd0, mem_write_en}, 32'd0);
        step();
        cmd_valid = 1'b0;
        chk("bp_taken", {31'd0, mem_write_en}, 32'd1);
        wait_ack(cyc);
        chk("bp_wr_ack_cycle", cyc, 32'd2);
        finish_txn(1'b1);

        // stability: command inputs churn during REQ
        wb0 = wb_count;
        issue(1'b1, 4'd12, 3'd4, 1'b1, 8'hC3);
        cyc = 0;
        for (int c = 1; c <= ACK_BUDGET && cyc == 0; c++) begin
            chk("stab_row", {28'd0, mem_row_addr}, 32'd12);
            chk("stab_data", {24'd0, mem_data_out}, 32'hC3);
            chk("stab_col_pad", {28'd0, mem_pad_en, mem_col_addr}, 32'hC);
            if (mem_ack) cyc = c;
            else begin
                cmd_row  = BAW'($urandom);
                cmd_data = TXW'($urandom);
                step();
            end
        end
        chk("stab_ack_cycle", cyc, 32'd3);
        finish_txn(1'b1);
        step();
        step();
        chk("stab_one_writeback", wb_count - wb0, 32'd1);
        chk("stab_bank_data", {24'd0, bank_mem[12][5]}, 32'hC3);

        // counter wrap with 2-bit count, then spurious ack in IDLE
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v = '{1'b1, 4'd1, 3'(i), 1'b0, 8'(8'h40 + i), (i == 0) ? 3 : 2, 8'h00};
            run_vec(v);
        end
        chk("wrap_txn_count", {30'd0, txn_count}, 32'd1);
        ack_inject = 1'b1;
        #1;
        chk("spur_wr_done", {31'd0, wr_done}, 32'd0);
        step();
        ack_inject = 1'b0;
        chk("spur_txn_count", {30'd0, txn_count}, 32'd1);
        chk("spur_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("spur_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("spur_enables", {30'd0, mem_write_en, mem_read_en}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
